// File: rtl/rv32im_decode_execute.sv
// RV32IM decode/execute slice: decodes the IF/ID instruction into an ID/EX register,
// then runs the base + M ALU and resolves branches and jumps combinationally in EX.
module rv32im_decode_execute #(
  parameter int XLEN = 32
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            BUSYWAIT,
  input  logic [XLEN-1:0] INSTRUCTION,
  input  logic [XLEN-1:0] PC,
  input  logic [XLEN-1:0] PC_PLUS_4,
  input  logic [XLEN-1:0] RS1_DATA,
  input  logic [XLEN-1:0] RS2_DATA,
  output logic [XLEN-1:0] EX_RESULT,
  output logic [XLEN-1:0] STORE_DATA,
  output logic [4:0]      RD_OUT,
  output logic [2:0]      FUNCT3_OUT,
  output logic            WRITE_ENABLE,
  output logic            MEM_READ,
  output logic            MEM_WRITE,
  output logic            MEM_TO_REG,
  output logic [XLEN-1:0] TARGET_ADDR,
  output logic            PC_MUX_CONTROL,
  output logic            REG_FLUSH
);

  typedef enum logic [4:0] {
    ALU_ADD    = 5'd0,  ALU_SUB   = 5'd1,  ALU_SLL    = 5'd2,  ALU_SLT   = 5'd3,
    ALU_SLTU   = 5'd4,  ALU_XOR   = 5'd5,  ALU_SRL    = 5'd6,  ALU_SRA   = 5'd7,
    ALU_OR     = 5'd8,  ALU_AND   = 5'd9,  ALU_MUL    = 5'd10, ALU_MULH  = 5'd11,
    ALU_MULHSU = 5'd12, ALU_MULHU = 5'd13, ALU_DIV    = 5'd14, ALU_DIVU  = 5'd15,
    ALU_REM    = 5'd16, ALU_REMU  = 5'd17, ALU_PASS2  = 5'd18
  } alu_op_e;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef struct packed {
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic [XLEN-1:0] store;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus_4;
    logic [XLEN-1:0] imm_b;
    alu_op_e         aluop;
    logic            we;
    logic            mem_read;
    logic            mem_write;
    logic            mem_to_reg;
    logic            branch;
    logic            jump;
    logic [2:0]      funct3;
    logic [4:0]      rd;
  } idex_t;

  function automatic alu_op_e base_op(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  logic [6:0]      w_opcode;
  logic [2:0]      w_funct3;
  logic [6:0]      w_funct7;
  logic [XLEN-1:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
  idex_t           w_dec;
  idex_t           r_idex;

  assign w_opcode = INSTRUCTION[6:0];
  assign w_funct3 = INSTRUCTION[14:12];
  assign w_funct7 = INSTRUCTION[31:25];
  assign w_imm_i  = {{20{INSTRUCTION[31]}}, INSTRUCTION[31:20]};
  assign w_imm_s  = {{20{INSTRUCTION[31]}}, INSTRUCTION[31:25], INSTRUCTION[11:7]};
  assign w_imm_b  = {{19{INSTRUCTION[31]}}, INSTRUCTION[31], INSTRUCTION[7],
                     INSTRUCTION[30:25], INSTRUCTION[11:8], 1'b0};
  assign w_imm_u  = {INSTRUCTION[31:12], 12'b0};
  assign w_imm_j  = {{11{INSTRUCTION[31]}}, INSTRUCTION[31], INSTRUCTION[19:12],
                     INSTRUCTION[20], INSTRUCTION[30:21], 1'b0};

  always_comb begin
    w_dec           = '0;
    w_dec.store     = RS2_DATA;
    w_dec.pc        = PC;
    w_dec.pc_plus_4 = PC_PLUS_4;
    w_dec.imm_b     = w_imm_b;
    w_dec.funct3    = w_funct3;
    w_dec.rd        = INSTRUCTION[11:7];
    case (w_opcode)
      OPC_LUI: begin
        w_dec.op2   = w_imm_u;
        w_dec.aluop = ALU_PASS2;
        w_dec.we    = 1'b1;
      end
      OPC_AUIPC: begin
        w_dec.op1 = PC;
        w_dec.op2 = w_imm_u;
        w_dec.we  = 1'b1;
      end
      OPC_JAL: begin
        w_dec.op1  = PC;
        w_dec.op2  = w_imm_j;
        w_dec.jump = 1'b1;
        w_dec.we   = 1'b1;
      end
      OPC_JALR: begin
        w_dec.op1  = RS1_DATA;
        w_dec.op2  = w_imm_i;
        w_dec.jump = 1'b1;
        w_dec.we   = 1'b1;
      end
      OPC_BRANCH: begin
        w_dec.op1    = RS1_DATA;
        w_dec.op2    = RS2_DATA;
        w_dec.branch = 1'b1;
      end
      OPC_LOAD: begin
        w_dec.op1        = RS1_DATA;
        w_dec.op2        = w_imm_i;
        w_dec.we         = 1'b1;
        w_dec.mem_read   = 1'b1;
        w_dec.mem_to_reg = 1'b1;
      end
      OPC_STORE: begin
        w_dec.op1       = RS1_DATA;
        w_dec.op2       = w_imm_s;
        w_dec.mem_write = 1'b1;
      end
      OPC_OPIMM: begin
        // Only shifts use bit 30 as a qualifier; ADDI's immediate may legitimately set it
        w_dec.op1   = RS1_DATA;
        w_dec.op2   = w_imm_i;
        w_dec.aluop = base_op(w_funct3, (w_funct3 == 3'b101) & INSTRUCTION[30]);
        w_dec.we    = 1'b1;
      end
      OPC_OP: begin
        w_dec.op1   = RS1_DATA;
        w_dec.op2   = RS2_DATA;
        w_dec.aluop = (w_funct7 == 7'b0000001) ? alu_op_e'(5'd10 + {2'b00, w_funct3})
                                                : base_op(w_funct3, INSTRUCTION[30]);
        w_dec.we    = 1'b1;
      end
      default: ;
    endcase
  end

  logic w_redirect;

  always_ff @(posedge CLK) begin
    if (RESET)
      r_idex <= '0;
    else if (!BUSYWAIT)
      r_idex <= w_redirect ? '0 : w_dec;
  end

  logic [XLEN-1:0] w_a, w_b, w_alu;
  logic [63:0]     w_prod;
  logic [XLEN-1:0] w_abs_a, w_abs_b, w_uquot, w_urem, w_quot_s, w_rem_s;
  logic            w_eq, w_lt, w_ltu, w_div0, w_cond, w_taken;

  assign w_a    = r_idex.op1;
  assign w_b    = r_idex.op2;
  assign w_eq   = (w_a == w_b);
  assign w_lt   = ($signed(w_a) < $signed(w_b));
  assign w_ltu  = (w_a < w_b);
  assign w_prod = {32'b0, w_a} * {32'b0, w_b};
  assign w_div0 = (w_b == '0);

  // Signed divide via magnitudes, so 0x80000000 / -1 falls out as 0x80000000 rem 0
  assign w_abs_a  = w_a[31] ? -w_a : w_a;
  assign w_abs_b  = w_b[31] ? -w_b : w_b;
  assign w_uquot  = w_abs_a / w_abs_b;
  assign w_urem   = w_abs_a % w_abs_b;
  assign w_quot_s = (w_a[31] ^ w_b[31]) ? -w_uquot : w_uquot;
  assign w_rem_s  = w_a[31] ? -w_urem : w_urem;

  always_comb begin
    w_alu = '0;
    case (r_idex.aluop)
      ALU_ADD:    w_alu = w_a + w_b;
      ALU_SUB:    w_alu = w_a - w_b;
      ALU_SLL:    w_alu = w_a << w_b[4:0];
      ALU_SLT:    w_alu = {31'b0, w_lt};
      ALU_SLTU:   w_alu = {31'b0, w_ltu};
      ALU_XOR:    w_alu = w_a ^ w_b;
      ALU_SRL:    w_alu = w_a >> w_b[4:0];
      ALU_SRA:    w_alu = $signed(w_a) >>> w_b[4:0];
      ALU_OR:     w_alu = w_a | w_b;
      ALU_AND:    w_alu = w_a & w_b;
      ALU_MUL:    w_alu = w_prod[31:0];
      // Signed high products corrected from the single unsigned product
      ALU_MULH:   w_alu = w_prod[63:32] - (w_a[31] ? w_b : '0) - (w_b[31] ? w_a : '0);
      ALU_MULHSU: w_alu = w_prod[63:32] - (w_a[31] ? w_b : '0);
      ALU_MULHU:  w_alu = w_prod[63:32];
      ALU_DIV:    w_alu = w_div0 ? '1 : w_quot_s;
      ALU_DIVU:   w_alu = w_div0 ? '1 : w_a / w_b;
      ALU_REM:    w_alu = w_div0 ? w_a : w_rem_s;
      ALU_REMU:   w_alu = w_div0 ? w_a : w_a % w_b;
      ALU_PASS2:  w_alu = w_b;
      default:    w_alu = '0;
    endcase
  end

  always_comb begin
    case (r_idex.funct3)
      3'b000:  w_cond = w_eq;
      3'b001:  w_cond = !w_eq;
      3'b100:  w_cond = w_lt;
      3'b101:  w_cond = !w_lt;
      3'b110:  w_cond = w_ltu;
      3'b111:  w_cond = !w_ltu;
      default: w_cond = 1'b0;
    endcase
  end

  assign w_taken    = r_idex.branch & w_cond;
  assign w_redirect = (w_taken | r_idex.jump) & !RESET;

  assign TARGET_ADDR    = r_idex.jump   ? {w_alu[XLEN-1:1], 1'b0} :
                          r_idex.branch ? r_idex.pc + r_idex.imm_b : '0;
  assign PC_MUX_CONTROL = w_redirect;
  assign REG_FLUSH      = w_redirect;
  assign EX_RESULT      = r_idex.jump ? r_idex.pc_plus_4 : w_alu;
  assign STORE_DATA     = r_idex.store;
  assign RD_OUT         = r_idex.rd;
  assign FUNCT3_OUT     = r_idex.funct3;
  assign WRITE_ENABLE   = r_idex.we;
  assign MEM_READ       = r_idex.mem_read;
  assign MEM_WRITE      = r_idex.mem_write;
  assign MEM_TO_REG     = r_idex.mem_to_reg;

endmodule

// File: tb/tb_rv32im_decode_execute.sv
// Bench for rv32im_decode_execute: directed vector table, hand sequences for
// flush/stall/reset, and random instructions against an instruction-level model.
module tb_rv32im_decode_execute;

  logic        CLK = 1'b0;
  logic        RESET, BUSYWAIT;
  logic [31:0] INSTRUCTION, PC, PC_PLUS_4, RS1_DATA, RS2_DATA;
  logic [31:0] EX_RESULT, STORE_DATA, TARGET_ADDR;
  logic [4:0]  RD_OUT;
  logic [2:0]  FUNCT3_OUT;
  logic        WRITE_ENABLE, MEM_READ, MEM_WRITE, MEM_TO_REG, PC_MUX_CONTROL, REG_FLUSH;

  int n_checks = 0;
  int n_errors = 0;

  rv32im_decode_execute dut (
    .CLK(CLK), .RESET(RESET), .BUSYWAIT(BUSYWAIT), .INSTRUCTION(INSTRUCTION),
    .PC(PC), .PC_PLUS_4(PC_PLUS_4), .RS1_DATA(RS1_DATA), .RS2_DATA(RS2_DATA),
    .EX_RESULT(EX_RESULT), .STORE_DATA(STORE_DATA), .RD_OUT(RD_OUT),
    .FUNCT3_OUT(FUNCT3_OUT), .WRITE_ENABLE(WRITE_ENABLE), .MEM_READ(MEM_READ),
    .MEM_WRITE(MEM_WRITE), .MEM_TO_REG(MEM_TO_REG), .TARGET_ADDR(TARGET_ADDR),
    .PC_MUX_CONTROL(PC_MUX_CONTROL), .REG_FLUSH(REG_FLUSH)
  );

  always #5 CLK = ~CLK;

  // ---------------- encoders ----------------
  function automatic logic [31:0] enc_r(logic [6:0] f7, logic [4:0] rs2, logic [4:0] rs1,
                                        logic [2:0] f3, logic [4:0] rd, logic [6:0] op);
    return {f7, rs2, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_i(logic [11:0] imm, logic [4:0] rs1, logic [2:0] f3,
                                        logic [4:0] rd, logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_s(logic [11:0] imm, logic [4:0] rs2, logic [4:0] rs1,
                                        logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] enc_b(logic [12:0] imm, logic [4:0] rs2, logic [4:0] rs1,
                                        logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
  endfunction
  function automatic logic [31:0] enc_j(logic [20:0] imm, logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6F};
  endfunction

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] res, target, store;
    logic        chk_res, we, mr, mw, m2r, redir;
    logic [4:0]  rd;
    logic [2:0]  f3;
  } exp_t;

  function automatic logic [31:0] sext(logic [31:0] v, int bits);
    return 32'($signed(v << (32 - bits)) >>> (32 - bits));
  endfunction

  function automatic logic [31:0] ref_base(logic [2:0] f3, logic alt, logic [31:0] a, logic [31:0] b);
    case (f3)
      3'd0: return alt ? a - b : a + b;
      3'd1: return a << b[4:0];
      3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3: return (a < b) ? 32'd1 : 32'd0;
      3'd4: return a ^ b;
      3'd5: return alt ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

  function automatic logic [31:0] ref_mext(logic [2:0] f3, logic [31:0] a, logic [31:0] b);
    longint      p;
    logic [63:0] pu;
    case (f3)
      3'd0: return a * b;
      3'd1: begin p = longint'($signed(a)) * longint'($signed(b)); return p[63:32]; end
      3'd2: begin p = longint'($signed(a)) * longint'({32'b0, b}); return p[63:32]; end
      3'd3: begin pu = {32'b0, a} * {32'b0, b}; return pu[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return 32'($signed(a) / $signed(b));
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return 32'($signed(a) % $signed(b));
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic exp_t ref_model(logic [31:0] ins, logic [31:0] pc, logic [31:0] x1, logic [31:0] x2);
    exp_t        e;
    logic [2:0]  f3 = ins[14:12];
    logic [31:0] imm_i = sext({20'b0, ins[31:20]}, 12);
    logic [31:0] imm_s = sext({20'b0, ins[31:25], ins[11:7]}, 12);
    logic [31:0] imm_b = sext({19'b0, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}, 13);
    logic [31:0] imm_j = sext({11'b0, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}, 21);
    logic [31:0] imm_u = {ins[31:12], 12'b0};
    logic        tk;
    e = '{res: 0, target: 0, store: x2, chk_res: 1, we: 0, mr: 0, mw: 0, m2r: 0,
          redir: 0, rd: ins[11:7], f3: f3};
    case (ins[6:0])
      7'h37: begin e.res = imm_u; e.we = 1; end
      7'h17: begin e.res = pc + imm_u; e.we = 1; end
      7'h6F: begin e.res = pc + 4; e.we = 1; e.redir = 1; e.target = (pc + imm_j) & ~32'd1; end
      7'h67: begin e.res = pc + 4; e.we = 1; e.redir = 1; e.target = (x1 + imm_i) & ~32'd1; end
      7'h63: begin
        case (f3)
          3'd0: tk = (x1 == x2);
          3'd1: tk = (x1 != x2);
          3'd4: tk = ($signed(x1) < $signed(x2));
          3'd5: tk = !($signed(x1) < $signed(x2));
          3'd6: tk = (x1 < x2);
          3'd7: tk = !(x1 < x2);
          default: tk = 0;
        endcase
        e.chk_res = 0; e.redir = tk; e.target = pc + imm_b;
      end
      7'h03: begin e.res = x1 + imm_i; e.we = 1; e.mr = 1; e.m2r = 1; end
      7'h23: begin e.res = x1 + imm_s; e.mw = 1; end
      7'h13: begin e.res = ref_base(f3, (f3 == 3'd5) && ins[30], x1, imm_i); e.we = 1; end
      7'h33: begin
        e.res = (ins[31:25] == 7'h01) ? ref_mext(f3, x1, x2) : ref_base(f3, ins[30], x1, x2);
        e.we = 1;
      end
      default: e.chk_res = 0;
    endcase
    return e;
  endfunction

  // ---------------- helpers ----------------
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(logic [31:0] ins, logic [31:0] pc, logic [31:0] x1, logic [31:0] x2);
    INSTRUCTION = ins; PC = pc; PC_PLUS_4 = pc + 4; RS1_DATA = x1; RS2_DATA = x2;
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_model(string tag, exp_t e);
    if (e.chk_res) chk({tag, " ex_result"}, EX_RESULT, e.res);
    chk({tag, " we"}, WRITE_ENABLE, e.we);
    chk({tag, " mem_read"}, MEM_READ, e.mr);
    chk({tag, " mem_write"}, MEM_WRITE, e.mw);
    chk({tag, " mem_to_reg"}, MEM_TO_REG, e.m2r);
    chk({tag, " pc_mux"}, PC_MUX_CONTROL, e.redir);
    chk({tag, " flush"}, REG_FLUSH, e.redir);
    if (e.redir) chk({tag, " target"}, TARGET_ADDR, e.target);
    chk({tag, " rd"}, RD_OUT, e.rd);
    chk({tag, " funct3"}, FUNCT3_OUT, e.f3);
    chk({tag, " store"}, STORE_DATA, e.store);
  endtask

  task automatic chk_bubble(string tag);
    chk({tag, " we"}, WRITE_ENABLE, 0);
    chk({tag, " mem_read"}, MEM_READ, 0);
    chk({tag, " mem_write"}, MEM_WRITE, 0);
    chk({tag, " mem_to_reg"}, MEM_TO_REG, 0);
    chk({tag, " pc_mux"}, PC_MUX_CONTROL, 0);
    chk({tag, " flush"}, REG_FLUSH, 0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // ---------------- directed table ----------------
  typedef struct {
    string       name;
    logic [31:0] ins, pc, x1, x2, res, target;
    logic        chk_res, we, mw, redir;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(string n, logic [31:0] ins, logic [31:0] pc, logic [31:0] x1,
                              logic [31:0] x2, logic cr, logic [31:0] res, logic we,
                              logic mw, logic rd, logic [31:0] tg);
    return '{name: n, ins: ins, pc: pc, x1: x1, x2: x2, res: res, target: tg,
             chk_res: cr, we: we, mw: mw, redir: rd};
  endfunction

  initial begin
    exp_t        e;
    logic [31:0] ins, pc, x1, x2;
    logic [2:0]  f3;
    logic [11:0] imm12;

    RESET = 1; BUSYWAIT = 0;
    drive(32'h0, 32'h0, 32'h0, 32'h0);
    step(); step();
    chk("reset ex_result", EX_RESULT, 0);
    chk("reset target", TARGET_ADDR, 0);
    chk("reset store", STORE_DATA, 0);
    chk("reset rd", RD_OUT, 0);
    chk_bubble("reset");
    RESET = 0;

    tbl.push_back(mk("add", enc_r(7'h00, 2, 1, 0, 3, 7'h33), 0, 5, 7, 1, 12, 1, 0, 0, 0));
    tbl.push_back(mk("beq", enc_b(13'd16, 2, 1, 0), 32'h100, 9, 9, 0, 0, 0, 0, 1, 32'h110));
    tbl.push_back(mk("div0", enc_r(7'h01, 2, 1, 4, 5, 7'h33), 0, 7, 0, 1, 32'hFFFF_FFFF, 1, 0, 0, 0));
    tbl.push_back(mk("rem0", enc_r(7'h01, 2, 1, 6, 5, 7'h33), 0, 7, 0, 1, 7, 1, 0, 0, 0));
    tbl.push_back(mk("divovf", enc_r(7'h01, 2, 1, 4, 5, 7'h33), 0, 32'h8000_0000, 32'hFFFF_FFFF,
                     1, 32'h8000_0000, 1, 0, 0, 0));
    tbl.push_back(mk("removf", enc_r(7'h01, 2, 1, 6, 5, 7'h33), 0, 32'h8000_0000, 32'hFFFF_FFFF,
                     1, 0, 1, 0, 0, 0));
    tbl.push_back(mk("mulhu", enc_r(7'h01, 2, 1, 3, 5, 7'h33), 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                     1, 32'hFFFF_FFFE, 1, 0, 0, 0));
    tbl.push_back(mk("mulh", enc_r(7'h01, 2, 1, 1, 5, 7'h33), 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                     1, 0, 1, 0, 0, 0));
    tbl.push_back(mk("mulhsu", enc_r(7'h01, 2, 1, 2, 5, 7'h33), 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                     1, 32'hFFFF_FFFF, 1, 0, 0, 0));
    tbl.push_back(mk("mul", enc_r(7'h01, 2, 1, 0, 5, 7'h33), 0, 32'h1_0000, 32'h1_0003,
                     1, 32'h3_0000, 1, 0, 0, 0));
    tbl.push_back(mk("divu0", enc_r(7'h01, 2, 1, 5, 5, 7'h33), 0, 32'h1234, 0, 1, 32'hFFFF_FFFF, 1, 0, 0, 0));
    tbl.push_back(mk("remu0", enc_r(7'h01, 2, 1, 7, 5, 7'h33), 0, 32'h1234, 0, 1, 32'h1234, 1, 0, 0, 0));
    tbl.push_back(mk("jalr", enc_i(12'h0, 1, 0, 1, 7'h67), 32'h40, 32'h203, 0, 1, 32'h44, 1, 0, 1, 32'h202));
    tbl.push_back(mk("sw", enc_s(12'd8, 2, 1, 2), 0, 32'h1000, 32'hDEAD, 1, 32'h1008, 0, 1, 0, 0));
    tbl.push_back(mk("sub", enc_r(7'h20, 2, 1, 0, 3, 7'h33), 0, 5, 7, 1, 32'hFFFF_FFFE, 1, 0, 0, 0));
    tbl.push_back(mk("sra", enc_r(7'h20, 2, 1, 5, 3, 7'h33), 0, 32'h8000_0000, 4, 1, 32'hF800_0000, 1, 0, 0, 0));
    tbl.push_back(mk("bne_nt", enc_b(13'd16, 2, 1, 1), 32'h100, 9, 9, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk("lui", {20'h12345, 5'd4, 7'h37}, 0, 0, 0, 1, 32'h1234_5000, 1, 0, 0, 0));
    tbl.push_back(mk("jal", enc_j(21'h20, 1), 32'h80, 0, 0, 1, 32'h84, 1, 0, 1, 32'hA0));
    tbl.push_back(mk("blt", enc_b(13'h1FF8, 2, 1, 4), 32'h200, 32'hFFFF_FFFF, 1, 0, 0, 0, 0, 1, 32'h1F8));
    tbl.push_back(mk("bltu_nt", enc_b(13'h1FF8, 2, 1, 6), 32'h200, 32'hFFFF_FFFF, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk("bad_op", 32'hFFFF_FFFF, 0, 1, 2, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk("slti", enc_i(12'd3, 1, 2, 4, 7'h13), 0, 32'hFFFF_FFFB, 0, 1, 1, 1, 0, 0, 0));
    tbl.push_back(mk("lw", enc_i(12'hFFC, 1, 2, 6, 7'h03), 0, 32'h1000, 0, 1, 32'hFFC, 1, 0, 0, 0));

    foreach (tbl[i]) begin
      drive(tbl[i].ins, tbl[i].pc, tbl[i].x1, tbl[i].x2);
      step();
      if (tbl[i].chk_res) chk({tbl[i].name, " ex_result"}, EX_RESULT, tbl[i].res);
      chk({tbl[i].name, " we"}, WRITE_ENABLE, tbl[i].we);
      chk({tbl[i].name, " mem_write"}, MEM_WRITE, tbl[i].mw);
      chk({tbl[i].name, " pc_mux"}, PC_MUX_CONTROL, tbl[i].redir);
      chk({tbl[i].name, " flush"}, REG_FLUSH, tbl[i].redir);
      if (tbl[i].redir) chk({tbl[i].name, " target"}, TARGET_ADDR, tbl[i].target);
      drive(32'h0, 0, 0, 0);
      step();
    end

    // Taken branch squashes the instruction behind it
    drive(enc_b(13'd16, 2, 1, 0), 32'h100, 9, 9);
    step();
    chk("flush_seq redirect", PC_MUX_CONTROL, 1);
    drive(enc_r(7'h00, 2, 1, 0, 3, 7'h33), 32'h104, 5, 7);
    step();
    chk_bubble("flush_seq bubble");
    chk("flush_seq bubble result", EX_RESULT, 0);
    step();
    chk("flush_seq resume", EX_RESULT, 12);
    chk("flush_seq resume rd", RD_OUT, 3);

    // Stall holds the ID/EX contents for three cycles
    BUSYWAIT = 1;
    drive(enc_r(7'h20, 2, 1, 0, 9, 7'h33), 32'h108, 100, 1);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("stall ex_result", EX_RESULT, 12);
      chk("stall rd", RD_OUT, 3);
      chk("stall we", WRITE_ENABLE, 1);
    end
    BUSYWAIT = 0;
    step();
    chk("stall release", EX_RESULT, 99);
    chk("stall release rd", RD_OUT, 9);

    // Reset mid-stream while a jump sits in EX
    drive(enc_j(21'h20, 1), 32'h80, 0, 0);
    step();
    chk("midreset jump", PC_MUX_CONTROL, 1);
    RESET = 1;
    #1;
    chk("midreset pc_mux forced", PC_MUX_CONTROL, 0);
    chk("midreset flush forced", REG_FLUSH, 0);
    step();
    chk_bubble("midreset");
    chk("midreset ex_result", EX_RESULT, 0);
    chk("midreset target", TARGET_ADDR, 0);
    RESET = 0;
    drive(32'h0, 0, 0, 0);
    step();

    // Random instructions against the model
    for (int it = 0; it < 400; it++) begin
      pc = {$urandom_range(0, 32'hFFFF), 2'b00};
      x1 = pick();
      x2 = pick();
      f3 = 3'($urandom_range(0, 7));
      imm12 = 12'($urandom);
      case ($urandom_range(0, 10))
        0: ins = {20'($urandom), 5'($urandom), 7'h37};
        1: ins = {20'($urandom), 5'($urandom), 7'h17};
        2: ins = enc_j(21'($urandom) & 21'h1FFFFE, 5'($urandom));
        3: ins = enc_i(imm12, 5'($urandom), 3'd0, 5'($urandom), 7'h67);
        4: begin
          if ($urandom_range(0, 1) == 1) x2 = x1;
          ins = enc_b(13'($urandom) & 13'h1FFE, 5'($urandom), 5'($urandom), f3);
        end
        5: ins = enc_i(imm12, 5'($urandom), f3, 5'($urandom), 7'h03);
        6: ins = enc_s(imm12, 5'($urandom), 5'($urandom), f3);
        7: begin
          if (f3 == 3'd0) imm12[10] = 1'b0;
          if (f3 == 3'd1) imm12[11:5] = 7'h00;
          if (f3 == 3'd5) imm12[11:5] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
          ins = enc_i(imm12, 5'($urandom), f3, 5'($urandom), 7'h13);
        end
        8: ins = enc_r((f3 == 3'd0 || f3 == 3'd5) && $urandom_range(0, 1) == 1 ? 7'h20 : 7'h00,
                       5'($urandom), 5'($urandom), f3, 5'($urandom), 7'h33);
        9: ins = enc_r(7'h01, 5'($urandom), 5'($urandom), f3, 5'($urandom), 7'h33);
        default: ins = {25'($urandom), 7'h7F};
      endcase
      e = ref_model(ins, pc, x1, x2);
      drive(ins, pc, x1, x2);
      step();
      chk_model($sformatf("rand%0d ins=%h", it, ins), e);
      if (e.redir) begin
        drive(enc_r(7'h00, 2, 1, 0, 3, 7'h33), pc + 4, 1, 1);
        step();
        chk_bubble($sformatf("rand%0d squash", it));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
